// File: rtl/tristate_slot_mux.sv
// Time-sliced shared-bus driver: CHANNELS free-running modulo counters take turns on one tristate bus.
// Latency: token/gap state changes one cycle after a slot/gap boundary; out follows the owning counter combinationally.
// Backpressure: enable=0 freezes the scheduler (slot/gap stretched); counters keep running. Option: COUNTER_RESYNC_EN.
module tristate_slot_mux #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int BASE_MAX = 10,
    parameter int MAX_STEP = 10,
    parameter int SLOT_LEN = 64,
    parameter int GAP_LEN  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    output logic [WIDTH-1:0]            out,
    output logic [CHANNELS-1:0]         active,
    output logic [$clog2(CHANNELS)-1:0] slot_idx,
    output logic                        gap
);

    localparam int IW = $clog2(CHANNELS);
    localparam int SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST  = (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;

    typedef enum logic {
        ST_SLOT = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        slot_cnt_q, slot_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [IW-1:0]        slot_idx_q, slot_idx_d;
    logic [CHANNELS-1:0]  active_q, active_d;
    logic [WIDTH-1:0]     cnt_q [CHANNELS];
    logic [WIDTH-1:0]     cnt_d [CHANNELS];
    logic [IW-1:0]        next_idx;
    logic                 rot;

    // Wrap value of channel i; truncated to the counter width.
    function automatic logic [WIDTH-1:0] max_val(input int i);
        int m;
        m = BASE_MAX + i * MAX_STEP;
        return m[WIDTH-1:0];
    endfunction

    // Scheduler next state: advance slot/gap counters, hand the token on at boundaries.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        slot_idx_d = slot_idx_q;
        active_d   = active_q;
        rot        = 1'b0;
        next_idx   = (slot_idx_q == IW'(CHANNELS - 1)) ? '0 : slot_idx_q + IW'(1);

        if (enable) begin
            case (state_q)
                ST_SLOT: begin
                    if (slot_cnt_q == SLOT_LAST) begin
                        if (GAP_LEN > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                            active_d  = '0;
                        end else begin
                            rot = 1'b1;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + SW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        rot = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    state_d = ST_SLOT;
                end
            endcase
        end

        // Rotation always lands in a fresh slot for the next channel.
        if (rot) begin
            state_d    = ST_SLOT;
            slot_cnt_d = '0;
            slot_idx_d = next_idx;
            active_d   = CHANNELS'(1) << next_idx;
        end
    end

    // Channel counters: free-running modulo (max_i + 1), optionally zeroed as their slot opens.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = (cnt_q[i] == max_val(i)) ? '0 : cnt_q[i] + WIDTH'(1);
`ifdef COUNTER_RESYNC_EN
            if (rot && (next_idx == IW'(i))) begin
                cnt_d[i] = '0;
            end
`endif
        end
    end

    // State registers; reset puts channel 0 on the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SLOT;
            slot_cnt_q <= '0;
            gap_cnt_q  <= '0;
            slot_idx_q <= '0;
            active_q   <= CHANNELS'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            slot_idx_q <= slot_idx_d;
            active_q   <= active_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign active   = active_q;
    assign slot_idx = slot_idx_q;
    assign gap      = (state_q == ST_GAP);
    // Only the token holder drives; bus floats during guard cycles.
    assign out      = (state_q == ST_SLOT) ? cnt_q[slot_idx_q] : {WIDTH{1'bz}};

endmodule
